// File: rtl/vreg_supervisor.sv
// rtl/vreg_supervisor.sv - MIC29201 regulator supervisor: soft-start, ERROR debounce, bounded retry, fault latch
module vreg_supervisor #(
    parameter int SOFTSTART_CYC  = 1000,
    parameter int DEBOUNCE_CYC   = 16,
    parameter int RETRY_WAIT_CYC = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       ERROR,
    input  logic       CLEAR_FAULT,
    output logic       SHUTDOWN,
    output logic       POWER_GOOD,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP,
        ST_ON,
        ST_BACKOFF,
        ST_FAULTED
    } state_t;

    // Timed states leave on the edge where the counter holds its last value,
    // so a window of N cycles compares against N-1.
    localparam logic [15:0] SS_LAST = 16'(SOFTSTART_CYC - 1);
    localparam logic [15:0] RW_LAST = 16'(RETRY_WAIT_CYC - 1);
    localparam logic [15:0] DB_DONE = 16'(DEBOUNCE_CYC);
    localparam logic [3:0]  MAX_RC  = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        err_s1_q, err_s2_q;
    logic        shutdown_q, shutdown_d;
    logic        pg_q, pg_d;
    logic        fault_q, fault_d;

    // Two-flop synchronizer for the asynchronous open-drain ERROR flag; idles high (no error).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_s1_q <= 1'b1;
            err_s2_q <= 1'b1;
        end else begin
            err_s1_q <= ERROR;
            err_s2_q <= err_s1_q;
        end
    end

    // Next-state, shared timer/debounce counter, retry bookkeeping and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_OFF: begin
                if (ENABLE) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (!ENABLE)               state_d = ST_OFF;
                else if (cnt_q == SS_LAST) state_d = ST_ON;
                else                       cnt_d   = cnt_q + 16'd1;
            end
            ST_ON: begin
                // Disable wins over a coincident debounce completion.
                if (!ENABLE) begin
                    state_d = ST_OFF;
                end else if (cnt_q == DB_DONE) begin
                    if (retry_q < MAX_RC) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_BACKOFF;
                    end else begin
                        state_d = ST_FAULTED;
                    end
                end else if (err_s2_q) begin
                    cnt_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_BACKOFF: begin
                if (!ENABLE)               state_d = ST_OFF;
                else if (cnt_q == RW_LAST) state_d = ST_RAMP;
                else                       cnt_d   = cnt_q + 16'd1;
            end
            ST_FAULTED: begin
                if (CLEAR_FAULT) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        // Every state starts its window from zero, and OFF forgets past restarts.
        if (state_d != state_q) cnt_d = 16'd0;
        if (state_d == ST_OFF)  retry_d = 4'd0;

        shutdown_d = (state_d == ST_OFF) || (state_d == ST_BACKOFF) || (state_d == ST_FAULTED);
        pg_d       = (state_d == ST_ON);
        fault_d    = (state_d == ST_FAULTED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_OFF;
            cnt_q      <= 16'd0;
            retry_q    <= 4'd0;
            shutdown_q <= 1'b1;
            pg_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            shutdown_q <= shutdown_d;
            pg_q       <= pg_d;
            fault_q    <= fault_d;
        end
    end

    assign SHUTDOWN    = shutdown_q;
    assign POWER_GOOD  = pg_q;
    assign FAULT       = fault_q;
    assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_vreg_supervisor.sv
// tb/tb_vreg_supervisor.sv - directed plus randomized bench for vreg_supervisor against a timeline reference model
module tb_vreg_supervisor;

    localparam int SS = 8;
    localparam int DB = 4;
    localparam int RW = 16;
    localparam int MR = 2;

    localparam int M_OFF  = 0;
    localparam int M_RAMP = 1;
    localparam int M_ON   = 2;
    localparam int M_BACK = 3;
    localparam int M_FLT  = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic       ERROR;
    logic       CLEAR_FAULT;
    logic       SHUTDOWN;
    logic       POWER_GOOD;
    logic       FAULT;
    logic [3:0] RETRY_COUNT;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, edge on which the mode was entered, restart count,
    // edge index since reset and the ERROR level sampled on every edge.
    int m_mode;
    int m_since;
    int m_rc;
    int t;
    bit raw_h[$];

    vreg_supervisor #(
        .SOFTSTART_CYC (SS),
        .DEBOUNCE_CYC  (DB),
        .RETRY_WAIT_CYC(RW),
        .MAX_RETRIES   (MR)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .ERROR      (ERROR),
        .CLEAR_FAULT(CLEAR_FAULT),
        .SHUTDOWN   (SHUTDOWN),
        .POWER_GOOD (POWER_GOOD),
        .FAULT      (FAULT),
        .RETRY_COUNT(RETRY_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ERROR as seen by the logic at edge j is the level sampled two edges earlier;
    // before reset history the synchronizer reads "no error".
    function automatic bit sync_low(int j);
        if (j - 2 < 0) return 1'b0;
        return raw_h[j - 2] == 1'b0;
    endfunction

    // Debounce completes at edge t when the D edges before it were all inside ON
    // and all saw a synchronized low.
    function automatic bit deb_done();
        if (t - m_since <= DB) return 1'b0;
        for (int j = t - DB; j < t; j++)
            if (!sync_low(j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode  = M_OFF;
        m_since = 0;
        m_rc    = 0;
        t       = 0;
        raw_h.delete();
    endtask

    task automatic go_mode(int mode);
        m_mode  = mode;
        m_since = t;
        if (mode == M_OFF) m_rc = 0;
    endtask

    task automatic model_step(bit en, bit clr, bit err);
        raw_h.push_back(err);
        case (m_mode)
            M_OFF:  if (en) go_mode(M_RAMP);
            M_RAMP: if (!en) go_mode(M_OFF);
                    else if (t - m_since == SS) go_mode(M_ON);
            M_ON: begin
                if (!en) go_mode(M_OFF);
                else if (deb_done()) begin
                    if (m_rc < MR) begin
                        m_rc++;
                        go_mode(M_BACK);
                    end else begin
                        go_mode(M_FLT);
                    end
                end
            end
            M_BACK: if (!en) go_mode(M_OFF);
                    else if (t - m_since == RW) go_mode(M_RAMP);
            default: if (clr) go_mode(M_OFF);
        endcase
        t++;
    endtask

    task automatic compare_model();
        check("m_shdn",  SHUTDOWN,    (m_mode == M_OFF || m_mode == M_BACK || m_mode == M_FLT));
        check("m_pg",    POWER_GOOD,  (m_mode == M_ON));
        check("m_fault", FAULT,       (m_mode == M_FLT));
        check("m_rc",    RETRY_COUNT, m_rc);
    endtask

    task automatic cycle(bit en, bit clr, bit err);
        ENABLE      = en;
        CLEAR_FAULT = clr;
        ERROR       = err;
        @(posedge CLK);
        model_step(en, clr, err);
        #1;
        compare_model();
    endtask

    // Reset is raised between edges and the outputs are checked before any clock edge.
    task automatic do_reset(string tag);
        #2 RESET = 1'b1;
        #1;
        check({tag, "_shdn"},  SHUTDOWN,    1);
        check({tag, "_pg"},    POWER_GOOD,  0);
        check({tag, "_fault"}, FAULT,       0);
        check({tag, "_rc"},    RETRY_COUNT, 0);
        model_reset();
        #2 RESET = 1'b0;
    endtask

    initial begin
        RESET       = 1'b1;
        ENABLE      = 1'b0;
        ERROR       = 1'b1;
        CLEAR_FAULT = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset("rst0");

        // Power-up: RAMP at edge 0, POWER_GOOD after edge 8.
        cycle(1, 0, 1);
        check("pu_shdn", SHUTDOWN, 0);
        for (int i = 1; i <= SS; i++) begin
            cycle(1, 0, 1);
            check("pu_pg", POWER_GOOD, int'(i == SS));
        end
        check("pu_fault", FAULT, 0);

        // Blanking: ERROR low through the ramp, then three synchronized-low cycles in ON.
        cycle(0, 0, 1);
        check("off_shdn", SHUTDOWN, 1);
        for (int i = 0; i <= SS; i++) cycle(1, 0, 0);
        check("bl_pg_on", POWER_GOOD, 1);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1);
        check("bl_pg", POWER_GOOD, 1);
        check("bl_rc", RETRY_COUNT, 0);

        // Retry: ERROR low from edge k, off after k+6, RAMP 16 later, ON 8 after that.
        for (int i = 0; i < DB + 2; i++) begin
            cycle(1, 0, 0);
            check("rt_hold", SHUTDOWN, 0);
        end
        cycle(1, 0, 1);
        check("rt_shdn", SHUTDOWN, 1);
        check("rt_cnt", RETRY_COUNT, 1);
        for (int i = 1; i <= RW; i++) begin
            cycle(1, 0, 1);
            check("rt_wait", SHUTDOWN, int'(i < RW));
        end
        for (int i = 1; i <= SS; i++) begin
            cycle(1, 0, 1);
            check("rt_pg", POWER_GOOD, int'(i == SS));
        end

        // Exhaustion: stuck-low ERROR drives retries to 2 then FAULT.
        for (int i = 0; i < 40; i++) cycle(1, 0, 0);
        check("ex_fault", FAULT, 1);
        check("ex_shdn", SHUTDOWN, 1);
        check("ex_rc", RETRY_COUNT, MR);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        for (int i = 0; i < 2; i++) cycle(1, 0, 1);
        check("ex_en_ign", FAULT, 1);
        cycle(1, 1, 1);
        check("clr_fault", FAULT, 0);
        check("clr_rc", RETRY_COUNT, 0);
        check("clr_shdn", SHUTDOWN, 1);
        cycle(1, 0, 1);
        check("clr_ramp", SHUTDOWN, 0);
        cycle(1, 1, 1);
        check("clr_ign", SHUTDOWN, 0);
        for (int i = 0; i < SS - 1; i++) cycle(1, 0, 1);
        check("re_on", POWER_GOOD, 1);

        // Disable on the debounce completion edge goes to OFF without a restart.
        for (int i = 0; i < DB + 2; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("race_shdn", SHUTDOWN, 1);
        check("race_pg", POWER_GOOD, 0);
        check("race_rc", RETRY_COUNT, 0);
        check("race_fault", FAULT, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);

        // Asynchronous reset in the middle of a BACKOFF window.
        for (int i = 0; i <= SS; i++) cycle(1, 0, 1);
        for (int i = 0; i < DB + 2; i++) cycle(1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1);
        check("bk_rc", RETRY_COUNT, 1);
        check("bk_shdn", SHUTDOWN, 1);
        do_reset("bk_rst");

        // Randomized traffic: ERROR bursts of random length and level, rare enable
        // flips, clear pulses and asynchronous resets.
        begin
            bit en     = 1'b1;
            bit err    = 1'b1;
            int burst  = 0;
            for (int n = 0; n < 4000; n++) begin
                if (burst == 0) begin
                    err   = ($urandom_range(0, 1) == 1);
                    burst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                                        : int'($urandom_range(1, 8));
                end
                burst--;
                if ($urandom_range(0, 59) == 0) en = ~en;
                if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
                cycle(en, ($urandom_range(0, 19) == 0), err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
